// File: rtl/hazard_detection_unit_pkg.sv
// Shared types and constants for the ID-stage hazard detection unit.
package hazard_detection_unit_pkg;

    localparam int unsigned N_BITS_REG_DEF   = 5;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned N_BITS_CNT_DEF   = 32;
    localparam int unsigned CNT_W            = 2;
    localparam int unsigned REG_ZERO         = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hdu_state_e;

    // Pipeline control bundle produced each cycle
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_enable;
    } hdu_ctrl_t;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side signal bundle of the hazard detection unit.
// Statistics outputs exist only when HAZARD_STATS_EN is defined.
interface hazard_detection_unit_if import hazard_detection_unit_pkg::*; #(
    parameter int unsigned N_BITS_REG = N_BITS_REG_DEF
`ifdef HAZARD_STATS_EN
   ,parameter int unsigned N_BITS_CNT = N_BITS_CNT_DEF
`endif
);

    logic                  i_enable;
    logic [N_BITS_REG-1:0] i_rs_IF_ID;
    logic [N_BITS_REG-1:0] i_rt_IF_ID;
    logic                  i_uses_rt_IF_ID;
    logic [N_BITS_REG-1:0] i_rt_ID_EX;
    logic                  i_memRead_ID_EX;
    logic                  i_branch_taken;
    logic                  i_halt_IF_ID;
    logic                  i_mem_busy;
    logic                  o_pc_write;
    logic                  o_if_id_write;
    logic                  o_if_id_flush;
    logic                  o_id_ex_bubble;
    logic                  o_pipe_enable;
    logic                  o_halted;
`ifdef HAZARD_STATS_EN
    logic [N_BITS_CNT-1:0] o_lu_stalls;
    logic [N_BITS_CNT-1:0] o_flushes;
`endif

    modport slave (
        input  i_enable, i_rs_IF_ID, i_rt_IF_ID, i_uses_rt_IF_ID, i_rt_ID_EX,
               i_memRead_ID_EX, i_branch_taken, i_halt_IF_ID, i_mem_busy,
`ifdef HAZARD_STATS_EN
        output o_lu_stalls, o_flushes,
`endif
        output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
               o_pipe_enable, o_halted
    );

    modport master (
        output i_enable, i_rs_IF_ID, i_rt_IF_ID, i_uses_rt_IF_ID, i_rt_ID_EX,
               i_memRead_ID_EX, i_branch_taken, i_halt_IF_ID, i_mem_busy,
`ifdef HAZARD_STATS_EN
        input  o_lu_stalls, o_flushes,
`endif
        input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble,
               o_pipe_enable, o_halted
    );

endinterface

// File: rtl/hazard_detection_unit_stats_counter.sv
// Saturating event counter; counts cycles where inc_i is high.
module hazard_stats_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use stall, branch flush, memory freeze, HALT drain.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_detection_unit import hazard_detection_unit_pkg::*; #(
    parameter int unsigned N_BITS_REG   = N_BITS_REG_DEF,
`ifdef HAZARD_STATS_EN
    parameter int unsigned N_BITS_CNT   = N_BITS_CNT_DEF,
`endif
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    hazard_detection_unit_if.slave hdu_if
);

    hdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    hdu_ctrl_t        ctrl;
    logic             frozen;
    logic             load_use;
    logic             lu_applied;
    logic             br_applied;

    // Load in EX writes a register the ID instruction reads; $0 never counts
    always_comb begin
        frozen   = !hdu_if.i_enable || hdu_if.i_mem_busy;
        load_use = hdu_if.i_memRead_ID_EX
                && (hdu_if.i_rt_ID_EX != N_BITS_REG'(REG_ZERO))
                && ((hdu_if.i_rt_ID_EX == hdu_if.i_rs_IF_ID)
                    || (hdu_if.i_uses_rt_IF_ID && (hdu_if.i_rt_ID_EX == hdu_if.i_rt_IF_ID)));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        halted_d   = halted_q;
        ctrl       = '0;
        lu_applied = 1'b0;
        br_applied = 1'b0;
        if (!frozen) begin
            ctrl.pipe_enable = 1'b1;
            case (state_q)
                ST_HALTED: begin
                    ctrl.id_ex_bubble = 1'b1;
                end
                ST_DRAIN: begin
                    ctrl.id_ex_bubble = 1'b1;
                    if (32'(cnt_q) == DRAIN_CYCLES - 1) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // Branch squashes the ID instruction, so it outranks load-use and HALT
                    if (hdu_if.i_branch_taken) begin
                        ctrl.pc_write     = 1'b1;
                        ctrl.if_id_flush  = 1'b1;
                        ctrl.id_ex_bubble = 1'b1;
                        br_applied        = 1'b1;
                        state_d           = ST_RUN;
                    end else if (load_use) begin
                        ctrl.id_ex_bubble = 1'b1;
                        lu_applied        = 1'b1;
                    end else if (hdu_if.i_halt_IF_ID) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.if_id_write = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign hdu_if.o_pc_write     = ctrl.pc_write;
    assign hdu_if.o_if_id_write  = ctrl.if_id_write;
    assign hdu_if.o_if_id_flush  = ctrl.if_id_flush;
    assign hdu_if.o_id_ex_bubble = ctrl.id_ex_bubble;
    assign hdu_if.o_pipe_enable  = ctrl.pipe_enable;
    assign hdu_if.o_halted       = halted_q;

`ifdef HAZARD_STATS_EN
    hazard_stats_counter #(.W(N_BITS_CNT)) u_lu_cnt (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .inc_i   (lu_applied),
        .count_o (hdu_if.o_lu_stalls)
    );

    hazard_stats_counter #(.W(N_BITS_CNT)) u_fl_cnt (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .inc_i   (br_applied),
        .count_o (hdu_if.o_flushes)
    );
`else
    logic unused_stats;
    assign unused_stats = lu_applied ^ br_applied;
`endif

endmodule
